// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator with a time-shared phase/triangle datapath.
// Ports: clk, rst (async high), ev_valid/ev_ready/ev_on/ev_key key events,
//   ev_drop reject pulse, active voice mask, pcm/pcm_valid mixed sample.
// Build option: SCHED_STEAL_EN makes a full note-on steal a voice
//   round-robin instead of dropping it.
module voice_scheduler #(
    parameter int NVOICES    = 4,
    parameter int ACC_W      = 28,
    parameter int INC_W      = 18,
    parameter int SAMPLE_DIV = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [3:0]         ev_key,
    output logic               ev_drop,
    output logic [NVOICES-1:0] active,
    output logic [15:0]        pcm,
    output logic               pcm_valid
);

    localparam int LG = $clog2(NVOICES);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int SW = 16 + LG;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UPD  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]       state;
    logic [LG-1:0]    v;
    logic [DW-1:0]    div;
    logic             tick;
    logic [ACC_W-1:0] acc [NVOICES];
    logic [INC_W-1:0] inc [NVOICES];
    logic [3:0]       key [NVOICES];
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_nxt;
    logic [ACC_W-1:0] acc_cur;
    logic [15:0]      tri_w;
    logic             hs;
    logic             hit;
    logic             fr;
    logic [LG-1:0]    hit_idx;
    logic [LG-1:0]    fr_idx;
`ifdef SCHED_STEAL_EN
    logic [LG-1:0]    rr_ptr;
`endif

    function automatic logic [INC_W-1:0] inc_of(input logic [3:0] k);
        logic [3:0]  s;
        logic [15:0] b;
        s = (k >= 4'd12) ? k - 4'd12 : k;
        case (s)
            4'd0:    b = 16'd8779;
            4'd1:    b = 16'd9301;
            4'd2:    b = 16'd9854;
            4'd3:    b = 16'd10440;
            4'd4:    b = 16'd11060;
            4'd5:    b = 16'd11718;
            4'd6:    b = 16'd12415;
            4'd7:    b = 16'd13153;
            4'd8:    b = 16'd13935;
            4'd9:    b = 16'd14764;
            4'd10:   b = 16'd15642;
            default: b = 16'd16572;
        endcase
        return (k >= 4'd12) ? INC_W'({b, 1'b0}) : INC_W'(b);
    endfunction

    assign tick      = (div == DW'(SAMPLE_DIV - 1));
    assign ev_ready  = (state == S_IDLE) && !rst;
    assign pcm_valid = (state == S_OUT);
    assign hs        = ev_valid && ev_ready;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        fr      = 1'b0;
        fr_idx  = '0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (active[i] && key[i] == ev_key) begin
                hit     = 1'b1;
                hit_idx = LG'(i);
            end
            if (!active[i]) begin
                fr     = 1'b1;
                fr_idx = LG'(i);
            end
        end
    end

    // Triangle folds on the accumulator MSB, using the pre-add value.
    always_comb begin
        acc_cur = acc[v];
        tri_w   = acc_cur[ACC_W-2 -: 16];
        if (acc_cur[ACC_W-1]) tri_w = ~tri_w;
        sum_nxt = sum + (active[v] ? SW'(tri_w) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            v       <= '0;
            div     <= '0;
            sum     <= '0;
            pcm     <= '0;
            active  <= '0;
            ev_drop <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                acc[i] <= '0;
                inc[i] <= '0;
                key[i] <= '0;
            end
`ifdef SCHED_STEAL_EN
            rr_ptr  <= '0;
`endif
        end else begin
            div     <= tick ? '0 : div + 1'b1;
            ev_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        if (ev_on) begin
                            if (hit) begin
                                acc[hit_idx] <= '0;
                            end else if (fr) begin
                                key[fr_idx]    <= ev_key;
                                inc[fr_idx]    <= inc_of(ev_key);
                                acc[fr_idx]    <= '0;
                                active[fr_idx] <= 1'b1;
                            end else begin
`ifdef SCHED_STEAL_EN
                                key[rr_ptr] <= ev_key;
                                inc[rr_ptr] <= inc_of(ev_key);
                                acc[rr_ptr] <= '0;
                                rr_ptr      <= rr_ptr + 1'b1;
`else
                                ev_drop <= 1'b1;
`endif
                            end
                        end else if (hit) begin
                            active[hit_idx] <= 1'b0;
                            acc[hit_idx]    <= '0;
                        end
                    end
                    if (tick) begin
                        state <= S_UPD;
                        v     <= '0;
                    end
                end
                S_UPD: begin
                    acc[v] <= active[v] ? acc[v] + ACC_W'(inc[v]) : '0;
                    sum    <= sum_nxt;
                    if (v == LG'(NVOICES - 1)) begin
                        state <= S_OUT;
                        // Loaded here so pcm is already new while pcm_valid is high.
                        pcm   <= 16'(sum_nxt >> LG);
                    end else begin
                        v <= v + 1'b1;
                    end
                end
                S_OUT: begin
                    sum   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
